branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Program-counter and branch-resolution stage that consumes the 1-bit registered `result` of the conditional unit.
- In normal flow it increments the PC once per enabled instruction.
- On a conditional-jump instruction (MD = 11) it stalls one cycle while the condition settles, then loads the jump target or falls through.
- Sits between the instruction decoder/register file and the instruction-memory address bus.

Parameters:
- ADDR_WIDTH, 8, width of the PC and jump target.
- RESET_VECTOR, 8'h00, PC value after reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  advance one instruction this cycle (RUN state only).
- is_cond_jump  input  1  decoder flag: current instruction is MD = 11.
- target_addr  input  ADDR_WIDTH  jump destination; sampled when the jump is accepted.
- cond_result  input  1  registered output of the conditional unit; valid in the cycle after opcode/operand were presented.
- halt_req  input  1  halt instruction decoded.
- pc  output  ADDR_WIDTH  current instruction address.
- stall  output  1  high while resolving a branch; upstream must hold instruction, opcode and operand stable.
- jump_taken  output  1  one-cycle pulse when the PC is loaded from the target.
- pc_wrapped  output  1  one-cycle pulse when an increment wraps from all-ones to 0.
- halted  output  1  high in HALT state.

Behaviour:
Reset
- reset_n low, async: pc = RESET_VECTOR; state = RUN; stall, jump_taken, pc_wrapped and halted all 0.
- Reset has priority over everything, including mid-COND_WAIT. A pending branch is discarded with no jump.

State machine (RUN, COND_WAIT, HALT)
- RUN, enable = 0: hold everything; pulses are 0.
- RUN, enable = 1, halt_req = 1: go to HALT; pc holds. halt_req has priority over is_cond_jump.
- RUN, enable = 1, is_cond_jump = 1:
  - latch target_addr into an internal register;
  - go to COND_WAIT; pc holds.
  - The conditional unit samples opcode/operand on this same edge.
- RUN, enable = 1, otherwise: pc <= pc + 1 (mod 2^ADDR_WIDTH). pc_wrapped pulses the next cycle if the old pc was all-ones.
- COND_WAIT: stall = 1 (combinational from state).
  - Resolves unconditionally in one cycle; enable is not sampled.
  - cond_result = 1: pc <= latched target; jump_taken = 1 for the following cycle.
  - cond_result = 0: pc <= pc + 1, with the same wrap rule.
  - Then return to RUN.
- HALT: halted = 1; pc frozen; all inputs ignored. Exit only via reset.

Timing and arithmetic
- Branch latency: 2 cycles from acceptance to new pc. Sequential instructions: 1 cycle.
- Arithmetic is unsigned, ADDR_WIDTH bits, silent wrap.
- A target equal to pc (self-loop) is legal and still pulses jump_taken.
- Outputs are registered, except stall, which is a decode of the state.

Decomposition:
- cpu_pkg holds:
  - typedef enum logic[1:0] seq_state_t {RUN, COND_WAIT, HALT};
  - localparam MD_COND_JUMP = 2'b11;
  - default ADDR_WIDTH constant.
- No sub-module; the incrementer and state machine stay in one module.

Test Plan:
- Reset, then enable = 1 with no jumps for 3 cycles: pc 00 → 01 → 02 → 03; stall never asserted.
- pc = 05, is_cond_jump = 1, target = 0x40, cond_result = 1 in the wait cycle: stall high 1 cycle; pc = 0x40; jump_taken pulses once.
- Same as above with cond_result = 0: pc = 0x06; jump_taken stays 0.
- pc = 0xFF, enable = 1: pc = 0x00 with pc_wrapped pulse. Repeat via a not-taken branch at 0xFF: same result.
- halt_req = 1 and is_cond_jump = 1 together at pc = 0x10: halted = 1, pc stays 0x10 for 5 cycles; then reset_n low gives pc = 00, halted = 0.
- reset_n asserted asynchronously mid-COND_WAIT (target 0x80): pc = 00 immediately; no jump_taken after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU sequencing and decode blocks.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        COND_WAIT = 2'd1,
        HALT      = 2'd2
    } seq_state_t;

    localparam logic [1:0] MD_COND_JUMP = 2'b11;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

endpackage

// File: rtl/branch_sequencer.sv
// Program counter with one-cycle branch resolution against the registered condition result.
module branch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  enable_i,
    input  logic                  is_cond_jump_i,
    input  logic [ADDR_WIDTH-1:0] target_addr_i,
    input  logic                  cond_result_i,
    input  logic                  halt_req_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  stall_o,
    output logic                  jump_taken_o,
    output logic                  pc_wrapped_o,
    output logic                  halted_o
);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  jump_taken_q, jump_taken_d;
    logic                  pc_wrapped_q, pc_wrapped_d;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  pc_at_max;

    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign pc_at_max = &pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        jump_taken_d = 1'b0;
        pc_wrapped_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (enable_i) begin
                    // halt outranks a simultaneous conditional jump
                    if (halt_req_i) begin
                        state_d = HALT;
                    end else if (is_cond_jump_i) begin
                        target_d = target_addr_i;
                        state_d  = COND_WAIT;
                    end else begin
                        pc_d         = pc_inc;
                        pc_wrapped_d = pc_at_max;
                    end
                end
            end
            COND_WAIT: begin
                if (cond_result_i) begin
                    pc_d         = target_q;
                    jump_taken_d = 1'b1;
                end else begin
                    pc_d         = pc_inc;
                    pc_wrapped_d = pc_at_max;
                end
                state_d = RUN;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= RUN;
            pc_q         <= RESET_VECTOR;
            target_q     <= '0;
            jump_taken_q <= 1'b0;
            pc_wrapped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            jump_taken_q <= jump_taken_d;
            pc_wrapped_q <= pc_wrapped_d;
        end
    end

    assign pc_o         = pc_q;
    assign stall_o      = (state_q == COND_WAIT);
    assign jump_taken_o = jump_taken_q;
    assign pc_wrapped_o = pc_wrapped_q;
    assign halted_o     = (state_q == HALT);

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed-vector bench for branch_sequencer with hand-computed expectations.
module tb_branch_sequencer;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       is_cond_jump;
    logic [7:0] target_addr;
    logic       cond_result;
    logic       halt_req;
    logic [7:0] pc;
    logic       stall;
    logic       jump_taken;
    logic       pc_wrapped;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;

    branch_sequencer #(
        .ADDR_WIDTH  (8),
        .RESET_VECTOR(8'h00)
    ) u_dut (
        .clock_i       (clock),
        .reset_n_i     (reset_n),
        .enable_i      (enable),
        .is_cond_jump_i(is_cond_jump),
        .target_addr_i (target_addr),
        .cond_result_i (cond_result),
        .halt_req_i    (halt_req),
        .pc_o          (pc),
        .stall_o       (stall),
        .jump_taken_o  (jump_taken),
        .pc_wrapped_o  (pc_wrapped),
        .halted_o      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Accept a conditional jump, then present the condition in the wait cycle.
    task automatic branch(input logic [7:0] tgt, input logic cond, input logic [7:0] pc_now);
        enable       = 1'b1;
        is_cond_jump = 1'b1;
        target_addr  = tgt;
        step();
        check("br_stall_hi", {31'd0, stall}, 32'd1);
        check("br_pc_hold", {24'd0, pc}, {24'd0, pc_now});
        enable       = 1'b0;
        is_cond_jump = 1'b0;
        target_addr  = 8'h00;
        cond_result  = cond;
        step();
        cond_result  = 1'b0;
        check("br_stall_lo", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        is_cond_jump = 1'b0;
        target_addr  = 8'h00;
        cond_result  = 1'b0;
        halt_req     = 1'b0;
        #3;
        check("rst_pc", {24'd0, pc}, 32'h00);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_jt", {31'd0, jump_taken}, 32'd0);
        check("rst_wrap", {31'd0, pc_wrapped}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        step();
        reset_n = 1'b1;

        // Sequential flow
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", {24'd0, pc}, i);
            check("seq_stall", {31'd0, stall}, 32'd0);
        end
        step();
        step();
        check("seq_pc5", {24'd0, pc}, 32'h05);

        // Taken branch at 0x05 to 0x40
        branch(8'h40, 1'b1, 8'h05);
        check("taken_pc", {24'd0, pc}, 32'h40);
        check("taken_jt", {31'd0, jump_taken}, 32'd1);
        step();
        check("taken_jt_once", {31'd0, jump_taken}, 32'd0);
        check("taken_pc_hold", {24'd0, pc}, 32'h40);

        // Back to 0x05 (self-check of taken path), then not taken
        branch(8'h05, 1'b1, 8'h40);
        check("back_pc", {24'd0, pc}, 32'h05);
        branch(8'h40, 1'b0, 8'h05);
        check("ntaken_pc", {24'd0, pc}, 32'h06);
        check("ntaken_jt", {31'd0, jump_taken}, 32'd0);

        // Wrap via sequential increment
        branch(8'hFF, 1'b1, 8'h06);
        check("ff_pc", {24'd0, pc}, 32'hFF);
        enable = 1'b1;
        step();
        enable = 1'b0;
        check("wrap_seq_pc", {24'd0, pc}, 32'h00);
        check("wrap_seq_pulse", {31'd0, pc_wrapped}, 32'd1);
        step();
        check("wrap_seq_once", {31'd0, pc_wrapped}, 32'd0);

        // Wrap via not-taken branch at 0xFF
        branch(8'hFF, 1'b1, 8'h00);
        branch(8'h33, 1'b0, 8'hFF);
        check("wrap_br_pc", {24'd0, pc}, 32'h00);
        check("wrap_br_pulse", {31'd0, pc_wrapped}, 32'd1);
        check("wrap_br_jt", {31'd0, jump_taken}, 32'd0);

        // Self-loop target still pulses jump_taken
        branch(8'h00, 1'b1, 8'h00);
        check("self_pc", {24'd0, pc}, 32'h00);
        check("self_jt", {31'd0, jump_taken}, 32'd1);

        // Halt beats cond jump at 0x10
        branch(8'h10, 1'b1, 8'h00);
        enable       = 1'b1;
        halt_req     = 1'b1;
        is_cond_jump = 1'b1;
        target_addr  = 8'hAA;
        step();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            enable       = 1'(i);
            is_cond_jump = 1'b1;
            cond_result  = 1'b1;
            halt_req     = 1'b0;
            step();
            check("halt_pc", {24'd0, pc}, 32'h10);
            check("halt_stays", {31'd0, halted}, 32'd1);
        end
        enable       = 1'b0;
        is_cond_jump = 1'b0;
        cond_result  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("halt_rst_pc", {24'd0, pc}, 32'h00);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        step();
        reset_n = 1'b1;

        // Async reset in the middle of COND_WAIT
        enable       = 1'b1;
        is_cond_jump = 1'b1;
        target_addr  = 8'h80;
        step();
        check("mid_stall", {31'd0, stall}, 32'd1);
        enable       = 1'b0;
        is_cond_jump = 1'b0;
        cond_result  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_pc", {24'd0, pc}, 32'h00);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        #1;
        reset_n = 1'b1;
        step();
        check("mid_no_jt", {31'd0, jump_taken}, 32'd0);
        check("mid_pc", {24'd0, pc}, 32'h00);
        step();
        check("mid_no_jt2", {31'd0, jump_taken}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
